proc_sequencer: RTL and testbench

//  Multi-cycle control sequencer for the Rx/Ry/A/G bus datapath. Captures one instruction,

---
 rtl/proc_sequencer_if.sv | 31 +++
 rtl/proc_sequencer.sv | 132 +++++++++++++
 tb/tb_proc_sequencer.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/proc_sequencer_if.sv
// Control bundle between the instruction sequencer and the Rx/Ry/A/G datapath.
// master = sequencer side, slave = instruction source / datapath side.
interface proc_sequencer_if #(
    parameter int NREG   = 4,
    parameter int RSEL_W = 2,
    parameter int IW     = 4 + 2 * RSEL_W
);
    logic            run;
    logic [IW-1:0]   instr;
    logic [NREG-1:0] rin;
    logic [NREG-1:0] rout;
    logic            din_out;
    logic            ai;
    logic            gi;
    logic            go;
    logic [1:0]      alu;
    logic            ldpc;
    logic            pc_inc;
    logic            busy;
    logic            done;

    modport master (
        input  run, instr,
        output rin, rout, din_out, ai, gi, go, alu, ldpc, pc_inc, busy, done
    );

    modport slave (
        output run, instr,
        input  rin, rout, din_out, ai, gi, go, alu, ldpc, pc_inc, busy, done
    );
endinterface

// File: rtl/proc_sequencer.sv
// Multi-cycle T1..T3 control sequencer for the shared-bus register/ALU datapath.
// Optional feature macro ILLEGAL_TRAP_EN: undefined opcodes halt and raise 'illegal'.
module proc_sequencer #(
    parameter int NREG   = 4,
    parameter int RSEL_W = 2,
    parameter int IW     = 4 + 2 * RSEL_W
) (
    input  logic               clk,
    input  logic               reset,
    proc_sequencer_if.master   bus
`ifdef ILLEGAL_TRAP_EN
    ,
    output logic               illegal
`endif
);
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        T1   = 3'd1,
        T2   = 3'd2,
        T3   = 3'd3,
        HALT = 3'd4
    } state_e;

    typedef enum logic [3:0] {
        OP_LOAD = 4'b0000,
        OP_MOV  = 4'b0001,
        OP_ADD  = 4'b0010,
        OP_XOR  = 4'b0011,
        OP_BR   = 4'b0101
    } op_e;

    state_e            state, nxt;
    logic [IW-1:0]     ir;
    logic [3:0]        op;
    logic [RSEL_W-1:0] rx, ry;
    logic              last;
    logic              cap;

    assign op = ir[IW-1 -: 4];
    assign rx = ir[2*RSEL_W-1 -: RSEL_W];
    assign ry = ir[RSEL_W-1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            ir    <= '0;
        end else begin
            state <= nxt;
            if (cap) ir <= bus.instr;
        end
    end

    // 'last' marks the final step; a capture there chains straight into T1.
    always_comb begin
        last = 1'b0;
        nxt  = state;
        case (state)
            IDLE: nxt = IDLE;
            T1: begin
                case (op)
                    OP_LOAD, OP_MOV, OP_BR: last = 1'b1;
                    OP_ADD, OP_XOR:         nxt  = T2;
                    default: begin
`ifdef ILLEGAL_TRAP_EN
                        nxt  = HALT;
`else
                        last = 1'b1;
`endif
                    end
                endcase
            end
            T2:      nxt  = T3;
            T3:      last = 1'b1;
            HALT:    nxt  = HALT;
            default: nxt  = IDLE;
        endcase
        cap = bus.run && !reset && ((state == IDLE) || last);
        if (cap)       nxt = T1;
        else if (last) nxt = IDLE;
    end

    always_comb begin
        bus.rin     = '0;
        bus.rout    = '0;
        bus.din_out = 1'b0;
        bus.ai      = 1'b0;
        bus.gi      = 1'b0;
        bus.go      = 1'b0;
        bus.alu     = 2'b00;
        bus.ldpc    = 1'b0;
        bus.pc_inc  = cap;
        bus.busy    = (state != IDLE);
        bus.done    = last;
        case (state)
            T1: begin
                case (op)
                    OP_LOAD: begin
                        bus.din_out = 1'b1;
                        bus.rin[rx] = 1'b1;
                    end
                    OP_MOV: begin
                        bus.rout[ry] = 1'b1;
                        bus.rin[rx]  = 1'b1;
                    end
                    OP_ADD, OP_XOR: begin
                        bus.rout[rx] = 1'b1;
                        bus.ai       = 1'b1;
                    end
                    OP_BR: begin
                        bus.din_out = 1'b1;
                        bus.ldpc    = 1'b1;
                    end
                    default: ;
                endcase
            end
            T2: begin
                bus.rout[ry] = 1'b1;
                bus.gi       = 1'b1;
                bus.alu      = (op == OP_XOR) ? 2'b10 : 2'b01;
            end
            T3: begin
                bus.go      = 1'b1;
                bus.rin[rx] = 1'b1;
            end
            default: ;
        endcase
    end

`ifdef ILLEGAL_TRAP_EN
    assign illegal = (state == HALT);
`endif
endmodule

// File: tb/tb_proc_sequencer.sv
// Directed, table-driven check of proc_sequencer against a small bus datapath model.
module tb_proc_sequencer;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    proc_sequencer_if #(.NREG(4), .RSEL_W(2), .IW(8)) sif ();
`ifdef ILLEGAL_TRAP_EN
    logic illegal;
`endif

    proc_sequencer #(.NREG(4), .RSEL_W(2), .IW(8)) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (sif.master)
`ifdef ILLEGAL_TRAP_EN
        ,
        .illegal (illegal)
`endif
    );

    // {rin, rout, din_out, ai, gi, go, alu, ldpc, pc_inc, busy, done}
    typedef struct {
        logic        rst;
        logic        run;
        logic [7:0]  instr;
        logic [7:0]  imm;
        logic [17:0] exp;
    } vec_t;

    vec_t tv[24];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Datapath model driven by the sequencer outputs
    logic [7:0] r [4];
    logic [7:0] a_q, g_q, pc_q, imm;
    int         viol = 0;

    always @(posedge clk) begin
        logic [7:0] bv;
        int         drv;
        bv  = '0;
        drv = 0;
        if (sif.din_out) begin bv = imm; drv++; end
        if (sif.go) begin bv = g_q; drv++; end
        for (int i = 0; i < 4; i++)
            if (sif.rout[i]) begin bv = r[i]; drv++; end
        if (drv > 1) viol <= viol + 1;
        for (int i = 0; i < 4; i++)
            if (sif.rin[i]) r[i] <= bv;
        if (sif.ai) a_q <= bv;
        if (sif.gi) g_q <= (sif.alu == 2'b01) ? a_q + bv :
                           (sif.alu == 2'b10) ? a_q ^ bv : 8'h00;
        if (sif.ldpc) pc_q <= bv;
    end

    function automatic logic [17:0] mk(logic [3:0] rin, logic [3:0] rout, logic din,
                                       logic ai, logic gi, logic go, logic [1:0] alu,
                                       logic ldpc, logic pci, logic busy, logic done);
        return {rin, rout, din, ai, gi, go, alu, ldpc, pci, busy, done};
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [17:0] outs();
        return {sif.rin, sif.rout, sif.din_out, sif.ai, sif.gi, sif.go, sif.alu,
                sif.ldpc, sif.pc_inc, sif.busy, sif.done};
    endfunction

    initial begin
        logic [17:0] nop_exp;
`ifdef ILLEGAL_TRAP_EN
        nop_exp = mk(4'b0000, 4'b0000, 0, 0, 0, 0, 2'b00, 0, 0, 1, 0);
`else
        nop_exp = mk(4'b0000, 4'b0000, 0, 0, 0, 0, 2'b00, 0, 0, 1, 1);
`endif
        //         rst run instr  imm    rin      rout    din ai gi go alu  ldpc pci busy done
        tv[0]  = '{0, 0, 8'h00, 8'h00, mk(4'b0000, 4'b0000, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0)};
        tv[1]  = '{0, 1, 8'h08, 8'h33, mk(4'b0000, 4'b0000, 0, 0, 0, 0, 2'b00, 0, 1, 0, 0)};
        tv[2]  = '{0, 0, 8'hF0, 8'h33, mk(4'b0100, 4'b0000, 1, 0, 0, 0, 2'b00, 0, 0, 1, 1)};
        tv[3]  = '{0, 1, 8'h04, 8'h05, mk(4'b0000, 4'b0000, 0, 0, 0, 0, 2'b00, 0, 1, 0, 0)};
        tv[4]  = '{0, 1, 8'h0C, 8'h05, mk(4'b0010, 4'b0000, 1, 0, 0, 0, 2'b00, 0, 1, 1, 1)};
        tv[5]  = '{0, 1, 8'h27, 8'h07, mk(4'b1000, 4'b0000, 1, 0, 0, 0, 2'b00, 0, 1, 1, 1)};
        tv[6]  = '{0, 0, 8'hFF, 8'h00, mk(4'b0000, 4'b0010, 0, 1, 0, 0, 2'b00, 0, 0, 1, 0)};
        tv[7]  = '{0, 1, 8'h55, 8'h00, mk(4'b0000, 4'b1000, 0, 0, 1, 0, 2'b01, 0, 0, 1, 0)};
        tv[8]  = '{0, 0, 8'h00, 8'h00, mk(4'b0010, 4'b0000, 0, 0, 0, 1, 2'b00, 0, 0, 1, 1)};
        tv[9]  = '{0, 1, 8'h00, 8'hA5, mk(4'b0000, 4'b0000, 0, 0, 0, 0, 2'b00, 0, 1, 0, 0)};
        tv[10] = '{0, 1, 8'h30, 8'hA5, mk(4'b0001, 4'b0000, 1, 0, 0, 0, 2'b00, 0, 1, 1, 1)};
        tv[11] = '{0, 1, 8'h30, 8'h00, mk(4'b0000, 4'b0001, 0, 1, 0, 0, 2'b00, 0, 0, 1, 0)};
        tv[12] = '{0, 1, 8'h30, 8'h00, mk(4'b0000, 4'b0001, 0, 0, 1, 0, 2'b10, 0, 0, 1, 0)};
        tv[13] = '{0, 1, 8'h1C, 8'h00, mk(4'b0001, 4'b0000, 0, 0, 0, 1, 2'b00, 0, 1, 1, 1)};
        tv[14] = '{0, 0, 8'h00, 8'h00, mk(4'b1000, 4'b0001, 0, 0, 0, 0, 2'b00, 0, 0, 1, 1)};
        tv[15] = '{0, 1, 8'h50, 8'h10, mk(4'b0000, 4'b0000, 0, 0, 0, 0, 2'b00, 0, 1, 0, 0)};
        tv[16] = '{0, 0, 8'h00, 8'h10, mk(4'b0000, 4'b0000, 1, 0, 0, 0, 2'b00, 1, 0, 1, 1)};
        tv[17] = '{0, 1, 8'h27, 8'h00, mk(4'b0000, 4'b0000, 0, 0, 0, 0, 2'b00, 0, 1, 0, 0)};
        tv[18] = '{0, 0, 8'h00, 8'h00, mk(4'b0000, 4'b0010, 0, 1, 0, 0, 2'b00, 0, 0, 1, 0)};
        tv[19] = '{1, 1, 8'h08, 8'h00, mk(4'b0000, 4'b1000, 0, 0, 1, 0, 2'b01, 0, 0, 1, 0)};
        tv[20] = '{1, 1, 8'h08, 8'h00, mk(4'b0000, 4'b0000, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0)};
        tv[21] = '{0, 0, 8'h08, 8'h00, mk(4'b0000, 4'b0000, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0)};
        tv[22] = '{0, 1, 8'hFF, 8'h00, mk(4'b0000, 4'b0000, 0, 0, 0, 0, 2'b00, 0, 1, 0, 0)};
        tv[23] = '{0, 0, 8'h00, 8'h00, nop_exp};

        reset = 1'b1;
        sif.run = 1'b0;
        sif.instr = '0;
        imm = '0;
        repeat (2) @(posedge clk);

        for (int i = 0; i < 24; i++) begin
            #1;
            reset     = tv[i].rst;
            sif.run   = tv[i].run;
            sif.instr = tv[i].instr;
            imm       = tv[i].imm;
            @(negedge clk);
            chk($sformatf("vec%0d", i), 32'(outs()), 32'(tv[i].exp));
            @(posedge clk);
        end

`ifdef ILLEGAL_TRAP_EN
        for (int i = 0; i < 3; i++) begin
            #1;
            sif.run = 1'b1;
            sif.instr = 8'h08;
            @(negedge clk);
            chk($sformatf("halt_outs%0d", i), 32'(outs()),
                32'(mk(4'b0000, 4'b0000, 0, 0, 0, 0, 2'b00, 0, 0, 1, 0)));
            chk($sformatf("halt_illegal%0d", i), 32'(illegal), 32'd1);
            @(posedge clk);
        end
        #1 reset = 1'b1;
        sif.run = 1'b0;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("halt_exit_outs", 32'(outs()), 32'd0);
        chk("halt_exit_illegal", 32'(illegal), 32'd0);
`else
        #1 sif.run = 1'b0;
        @(negedge clk);
        chk("nop_back_idle", 32'(outs()), 32'd0);
`endif

        chk("R2_load", 32'(r[2]), 32'h33);
        chk("R1_add_kept", 32'(r[1]), 32'd12);
        chk("R0_xor_self", 32'(r[0]), 32'd0);
        chk("R3_mov", 32'(r[3]), 32'd0);
        chk("PC_br", 32'(pc_q), 32'h10);
        chk("bus_single_driver", 32'(viol), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
